// File: rtl/amiga_kbd_link_pkg.sv
// Shared types and constants for the Amiga keyboard serial link.
// Holds the top FSM and bit-phase encodings plus the protocol byte values.
package amiga_kbd_link_pkg;

    typedef enum logic [3:0] {
        IDLE,
        SETUP,
        CLK_LOW,
        CLK_HIGH,
        ACK_WAIT,
        ACK_RELEASE,
        RSYNC_SETUP,
        RSYNC_LOW,
        RSYNC_HIGH
    } kbd_state_e;

    typedef enum logic [1:0] {
        PH_IDLE,
        PH_SETUP,
        PH_LOW,
        PH_HIGH
    } bit_phase_e;

    localparam logic [7:0] KBD_INIT_POWERUP = 8'hFD;
    localparam logic [7:0] KBD_INIT_TERM    = 8'hFE;
    localparam logic [7:0] KBD_LOST_SYNC    = 8'hF9;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/amiga_kbd_bit_shifter.sv
// Clocks one 8-bit frame (or a single resync 1-bit) out on KCLK/KDAT.
// Each bit runs SETUP -> LOW -> HIGH; done pulses in the last HIGH cycle.
module amiga_kbd_bit_shifter
    import amiga_kbd_link_pkg::*;
#(
    parameter int T_SETUP = 1000,
    parameter int T_LOW   = 1000,
    parameter int T_HIGH  = 1000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       one_bit,
    input  logic [7:0] frame,
    output logic       done,
    output bit_phase_e phase_nxt,
    output logic       kclk_oe,
    output logic       kdat_oe
);

    localparam int TW = $clog2(max3(T_SETUP, T_LOW, T_HIGH) + 1);

    bit_phase_e    phase_q, phase_d;
    logic [TW-1:0] cnt_q, cnt_d;
    logic [TW-1:0] lim;
    logic [TW-1:0] cnt_inc;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    frame_q, frame_d;
    logic          one_q, one_d;
    logic          cur_bit;

    // Send order is F6..F0 then F7: index 6-bit wraps to 7 on the last bit.
    assign cur_bit   = one_q | frame_q[3'd6 - bit_q];
    assign kclk_oe   = (phase_q == PH_LOW);
    assign kdat_oe   = cur_bit & ((phase_q == PH_SETUP) || (phase_q == PH_LOW) ||
                                  ((phase_q == PH_HIGH) && !one_q));
    assign phase_nxt = phase_d;
    assign cnt_inc   = (cnt_q == {TW{1'b1}}) ? cnt_q : cnt_q + 1'b1;

    always_comb begin
        phase_d = phase_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        frame_d = frame_q;
        one_d   = one_q;
        done    = 1'b0;
        case (phase_q)
            PH_SETUP: lim = TW'(T_SETUP - 1);
            PH_LOW:   lim = TW'(T_LOW - 1);
            default:  lim = TW'(T_HIGH - 1);
        endcase
        case (phase_q)
            PH_IDLE: begin
                if (start) begin
                    frame_d = frame;
                    one_d   = one_bit;
                    bit_d   = 3'd0;
                    cnt_d   = '0;
                    phase_d = PH_SETUP;
                end
            end
            PH_SETUP, PH_LOW: begin
                if (cnt_q == lim) begin
                    cnt_d   = '0;
                    phase_d = (phase_q == PH_SETUP) ? PH_LOW : PH_HIGH;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            default: begin
                if (cnt_q == lim) begin
                    cnt_d = '0;
                    if (one_q || bit_q == 3'd7) begin
                        phase_d = PH_IDLE;
                        done    = 1'b1;
                    end else begin
                        bit_d   = bit_q + 3'd1;
                        phase_d = PH_SETUP;
                    end
                end else begin
                    cnt_d = cnt_inc;
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            phase_q <= PH_IDLE;
            cnt_q   <= '0;
            bit_q   <= 3'd0;
            frame_q <= 8'h00;
            one_q   <= 1'b0;
        end else begin
            phase_q <= phase_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            frame_q <= frame_d;
            one_q   <= one_d;
        end
    end

endmodule

// File: rtl/amiga_kbd_link.sv
// Keyboard-side Amiga serial link: power-up sync, key frames, host handshake
// and lost-sync recovery (resync pulses, $F9, retransmit).
module amiga_kbd_link
    import amiga_kbd_link_pkg::*;
#(
    parameter int T_SETUP     = 1000,
    parameter int T_LOW       = 1000,
    parameter int T_HIGH      = 1000,
    parameter int ACK_MIN     = 50,
    parameter int ACK_TIMEOUT = 7150000
) (
    input  logic       CLK,
    input  logic       RES,
    input  logic       KEY_VALID,
    input  logic [6:0] KEY_CODE,
    input  logic       KEY_UP,
    output logic       KEY_READY,
    output logic       KCLK_OE,
    output logic       KDAT_OE,
    input  logic       KDAT_IN,
    output logic       SYNCED
);

    localparam int AW  = $clog2(ACK_MIN + 1);
    localparam int TOW = $clog2(ACK_TIMEOUT + 1);

    kbd_state_e     state_q, state_d;
    logic [7:0]     q0_q, q0_d, q1_q, q1_d;
    logic [1:0]     qcnt_q, qcnt_d;
    logic [7:0]     cur_q, cur_d;
    logic           synced_q, synced_d;
    logic           rsync_q, rsync_d;
    logic           recov_q, recov_d;
    logic [AW-1:0]  low_q, low_d;
    logic [TOW-1:0] to_q, to_d;

    logic       sh_start, sh_one, sh_done;
    logic [7:0] sh_frame;
    bit_phase_e sh_phase_nxt;
    logic       key_ready;

    amiga_kbd_bit_shifter #(
        .T_SETUP(T_SETUP),
        .T_LOW  (T_LOW),
        .T_HIGH (T_HIGH)
    ) u_shifter (
        .clk      (CLK),
        .rst      (RES),
        .start    (sh_start),
        .one_bit  (sh_one),
        .frame    (sh_frame),
        .done     (sh_done),
        .phase_nxt(sh_phase_nxt),
        .kclk_oe  (KCLK_OE),
        .kdat_oe  (KDAT_OE)
    );

    assign key_ready = (state_q == IDLE) && synced_q && (qcnt_q == 2'd0);
    assign KEY_READY = key_ready;
    assign SYNCED    = synced_q;

    always_comb begin
        state_d  = state_q;
        q0_d     = q0_q;
        q1_d     = q1_q;
        qcnt_d   = qcnt_q;
        cur_d    = cur_q;
        synced_d = synced_q;
        rsync_d  = rsync_q;
        recov_d  = recov_q;
        low_d    = low_q;
        to_d     = to_q;
        sh_start = 1'b0;
        sh_one   = 1'b0;
        sh_frame = q0_q;
        case (state_q)
            IDLE: begin
                if (qcnt_q != 2'd0) begin
                    sh_start = 1'b1;
                    cur_d    = q0_q;
                    q0_d     = q1_q;
                    qcnt_d   = qcnt_q - 2'd1;
                    state_d  = SETUP;
                end else if (key_ready && KEY_VALID) begin
                    sh_start = 1'b1;
                    sh_frame = {KEY_UP, KEY_CODE};
                    cur_d    = {KEY_UP, KEY_CODE};
                    state_d  = SETUP;
                end
            end
            ACK_WAIT: begin
                to_d  = (to_q == {TOW{1'b1}}) ? to_q : to_q + 1'b1;
                low_d = KDAT_IN ? '0 : ((low_q == {AW{1'b1}}) ? low_q : low_q + 1'b1);
                if (!KDAT_IN && low_q == AW'(ACK_MIN - 1)) begin
                    state_d = ACK_RELEASE;
                    if (!rsync_q && cur_q == KBD_INIT_TERM)
                        synced_d = 1'b1;
                end else if (to_q == TOW'(ACK_TIMEOUT - 1)) begin
                    sh_start = 1'b1;
                    sh_one   = 1'b1;
                    rsync_d  = 1'b1;
                    state_d  = RSYNC_SETUP;
                end
            end
            ACK_RELEASE: begin
                if (KDAT_IN) begin
                    state_d = IDLE;
                    if (rsync_q) begin
                        // If the lost frame was itself the recovery $F9, the saved frame is already in q0.
                        rsync_d = 1'b0;
                        recov_d = 1'b1;
                        q0_d    = KBD_LOST_SYNC;
                        q1_d    = recov_q ? q0_q : cur_q;
                        qcnt_d  = 2'd2;
                    end else begin
                        recov_d = 1'b0;
                        if (!synced_q && cur_q == KBD_INIT_POWERUP) begin
                            q0_d   = KBD_INIT_TERM;
                            qcnt_d = 2'd1;
                        end
                    end
                end
            end
            default: begin
                if (sh_done) begin
                    state_d = ACK_WAIT;
                    low_d   = '0;
                    to_d    = '0;
                end else begin
                    case (sh_phase_nxt)
                        PH_LOW:  state_d = rsync_q ? RSYNC_LOW  : CLK_LOW;
                        PH_HIGH: state_d = rsync_q ? RSYNC_HIGH : CLK_HIGH;
                        default: state_d = rsync_q ? RSYNC_SETUP : SETUP;
                    endcase
                end
            end
        endcase
    end

    always_ff @(posedge CLK or posedge RES) begin
        if (RES) begin
            state_q  <= IDLE;
            q0_q     <= KBD_INIT_POWERUP;
            q1_q     <= 8'h00;
            qcnt_q   <= 2'd1;
            cur_q    <= 8'h00;
            synced_q <= 1'b0;
            rsync_q  <= 1'b0;
            recov_q  <= 1'b0;
            low_q    <= '0;
            to_q     <= '0;
        end else begin
            state_q  <= state_d;
            q0_q     <= q0_d;
            q1_q     <= q1_d;
            qcnt_q   <= qcnt_d;
            cur_q    <= cur_d;
            synced_q <= synced_d;
            rsync_q  <= rsync_d;
            recov_q  <= recov_d;
            low_q    <= low_d;
            to_q     <= to_d;
        end
    end

endmodule

// File: tb/tb_amiga_kbd_link.sv
// Directed bench for amiga_kbd_link with short timing parameters.
module tb_amiga_kbd_link;

    localparam int TS = 4, TL = 4, TH = 4, AM = 3, AT = 200;

    logic       CLK = 1'b0;
    logic       RES = 1'b1;
    logic       KEY_VALID = 1'b0;
    logic [6:0] KEY_CODE = 7'h00;
    logic       KEY_UP = 1'b0;
    logic       KDAT_IN = 1'b1;
    logic       KEY_READY, KCLK_OE, KDAT_OE, SYNCED;

    int checks = 0;
    int failures = 0;
    int acc_cnt = 0;

    always #5 CLK = ~CLK;

    amiga_kbd_link #(
        .T_SETUP(TS), .T_LOW(TL), .T_HIGH(TH), .ACK_MIN(AM), .ACK_TIMEOUT(AT)
    ) dut (
        .CLK(CLK), .RES(RES), .KEY_VALID(KEY_VALID), .KEY_CODE(KEY_CODE),
        .KEY_UP(KEY_UP), .KEY_READY(KEY_READY), .KCLK_OE(KCLK_OE),
        .KDAT_OE(KDAT_OE), .KDAT_IN(KDAT_IN), .SYNCED(SYNCED)
    );

    always @(posedge CLK) if (!RES && KEY_VALID && KEY_READY) acc_cnt <= acc_cnt + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge: waits for the next KCLK pulse, samples KDAT at its start and measures it.
    task automatic wait_pulse(input int budget, output int dly, output logic dat, output int w);
        dly = 0; w = 0; dat = 1'b0;
        while (!KCLK_OE && dly < budget) begin @(negedge CLK); dly++; end
        if (KCLK_OE) begin
            dat = KDAT_OE;
            while (KCLK_OE && w < budget) begin @(negedge CLK); w++; end
        end
    endtask

    task automatic capture_frame(output logic [7:0] pat, output int wbad);
        int d, w;
        logic b;
        wbad = 0;
        pat = 8'h00;
        for (int i = 0; i < 8; i++) begin
            wait_pulse(300, d, b, w);
            pat[7-i] = b;
            if (w != TL) wbad++;
        end
    endtask

    task automatic host_ack(input int lows);
        repeat (6) @(negedge CLK);
        KDAT_IN = 1'b0;
        repeat (lows) @(negedge CLK);
        KDAT_IN = 1'b1;
        repeat (2) @(negedge CLK);
    endtask

    initial begin
        logic [7:0] pat;
        int wbad, d, w, n, pulses;
        logic b, prev;

        repeat (3) @(negedge CLK);
        chk("rst_kclk_oe", KCLK_OE, 0);
        chk("rst_kdat_oe", KDAT_OE, 0);
        chk("rst_key_ready", KEY_READY, 0);
        chk("rst_synced", SYNCED, 0);
        RES = 1'b0;

        // Power-up: $FD then $FE
        capture_frame(pat, wbad);
        chk("fd_pattern", pat, 8'hFB);
        chk("fd_kclk_width", wbad, 0);
        chk("fd_synced", SYNCED, 0);
        host_ack(5);
        capture_frame(pat, wbad);
        chk("fe_pattern", pat, 8'hFD);
        chk("fe_kclk_width", wbad, 0);
        host_ack(5);
        chk("synced_after_fe", SYNCED, 1);
        chk("ready_after_sync", KEY_READY, 1);

        // Key $45 press, KEY_VALID held across two IDLE entries
        KEY_CODE = 7'h45; KEY_UP = 1'b0; KEY_VALID = 1'b1;
        @(negedge CLK);
        chk("ready_in_frame", KEY_READY, 0);
        chk("acc_first", acc_cnt, 1);
        capture_frame(pat, wbad);
        chk("key45_pattern", pat, 8'h8A);
        chk("key45_kclk_width", wbad, 0);
        chk("ready_before_ack", KEY_READY, 0);
        host_ack(5);
        KEY_VALID = 1'b0;
        chk("acc_held_valid", acc_cnt, 2);
        capture_frame(pat, wbad);
        chk("key45_again_pattern", pat, 8'h8A);

        // No ack: resync bit after the timeout
        wait_pulse(400, d, b, w);
        chk("rsync1_delay", d, 208);
        chk("rsync1_kdat", b, 1);
        chk("rsync1_width", w, 4);

        // 2-cycle glitch must neither ack nor restart the timeout
        n = 0;
        while (!KCLK_OE && n < 400) begin
            if (n == 20) KDAT_IN = 1'b0;
            if (n == 22) KDAT_IN = 1'b1;
            @(negedge CLK);
            n++;
        end
        chk("rsync2_delay", n, 208);
        chk("rsync2_kdat", KDAT_OE, 1);
        w = 0;
        while (KCLK_OE && w < 50) begin @(negedge CLK); w++; end

        // Exactly ACK_MIN low cycles acks the resync -> $F9, then retransmit
        host_ack(3);
        capture_frame(pat, wbad);
        chk("f9_pattern", pat, 8'hF3);
        chk("f9_kclk_width", wbad, 0);
        host_ack(5);
        capture_frame(pat, wbad);
        chk("retx_pattern", pat, 8'h8A);
        host_ack(5);
        chk("ready_after_retx", KEY_READY, 1);
        chk("acc_after_retx", acc_cnt, 2);

        // Reset during CLK_LOW of bit 3 of frame $8F (F3 = 1)
        KEY_CODE = 7'h0F; KEY_UP = 1'b1; KEY_VALID = 1'b1;
        @(negedge CLK);
        KEY_VALID = 1'b0;
        pulses = 0; n = 0; prev = 1'b0;
        while (pulses < 4 && n < 300) begin
            @(negedge CLK);
            n++;
            if (KCLK_OE && !prev) pulses++;
            prev = KCLK_OE;
        end
        chk("mid_pre_kclk", KCLK_OE, 1);
        chk("mid_pre_kdat", KDAT_OE, 1);
        RES = 1'b1;
        #1;
        chk("mid_rst_kclk", KCLK_OE, 0);
        chk("mid_rst_kdat", KDAT_OE, 0);
        @(negedge CLK);
        RES = 1'b0;
        chk("mid_rst_synced", SYNCED, 0);
        capture_frame(pat, wbad);
        chk("fd_restart_pattern", pat, 8'hFB);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
